// File: rtl/mtimer_if.sv
// mtimer_if: word-wide data-bus link between the core (master) and the
// machine timer (slave).
//   addr   : word byte-address, bits [1:0] ignored by the slave
//   wdata  : write data
//   we     : write enable, active low
//   re     : read enable, active low
//   rdata  : registered read data
//   rvalid : rdata valid, one-cycle active-high pulse
interface mtimer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output addr,
        output wdata,
        output we,
        output re,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        input  re,
        output rdata,
        output rvalid
    );
endinterface

// File: rtl/mtimer.sv
// mtimer: machine-timer source for the CSR/interrupt unit.
// Holds a free-running 64-bit mtime and a 64-bit mtimecmp, both
// word-accessible over the data bus, and drives the active-low timer
// interrupt while mtime >= mtimecmp. Rewriting mtimecmp is the only way
// software clears the interrupt.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : mtimer_if.slave (addr, wdata, we_n, re_n, rdata, rvalid)
//   ti   : timer interrupt, active low, registered
//
// Register map (offsets from BASE):
//   0x4000 mtimecmp[31:0]   0x4004 mtimecmp[63:32]
//   0xBFF8 mtime[31:0]      0xBFFC mtime[63:32]
//
// Build option: define MTIMER_SNAPSHOT_EN to latch mtime[63:32] into a
// shadow register whenever mtime[31:0] is read; reads of 0xBFFC then
// return the shadow, giving a coherent 64-bit read. Without it, 0xBFFC
// returns the live high word and software uses the hi-lo-hi retry.
module mtimer #(
    parameter logic [31:0] BASE     = 32'h0200_0000,
    parameter int unsigned PRESCALE = 1
) (
    input  logic           clk,
    input  logic           rst,
    mtimer_if.slave        bus,
    output logic           ti
);

    localparam logic [31:0] A_CMP_LO  = BASE + 32'h0000_4000;
    localparam logic [31:0] A_CMP_HI  = BASE + 32'h0000_4004;
    localparam logic [31:0] A_TIME_LO = BASE + 32'h0000_BFF8;
    localparam logic [31:0] A_TIME_HI = BASE + 32'h0000_BFFC;
    localparam logic [15:0] PS_LAST   = 16'(PRESCALE - 1);

    logic [15:0] ps_cnt_q, ps_cnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q;
    logic        ti_q;

    logic        tick;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] addr_w;
    logic [31:0] rd_word;

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;
`endif

    assign wr_en  = ~bus.we;
    assign rd_en  = ~bus.re;
    assign addr_w = bus.addr & 32'hFFFF_FFFC;

    // Counter state and timer update. A bus write to either mtime half
    // replaces the increment for that cycle entirely (no carry either).
    always_comb begin
        tick       = (ps_cnt_q == PS_LAST);
        ps_cnt_d   = tick ? 16'd0 : ps_cnt_q + 16'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_en) begin
            case (addr_w)
                A_CMP_LO:  mtimecmp_d[31:0]  = bus.wdata;
                A_CMP_HI:  mtimecmp_d[63:32] = bus.wdata;
                A_TIME_LO: mtime_d = {mtime_q[63:32], bus.wdata};
                A_TIME_HI: mtime_d = {bus.wdata, mtime_q[31:0]};
                default:   ;
            endcase
        end
    end

    // Read mux works on pre-edge register values, so a same-cycle write
    // to the read address is not visible until the next read.
    always_comb begin
        rd_word = 32'd0;
        case (addr_w)
            A_CMP_LO:  rd_word = mtimecmp_q[31:0];
            A_CMP_HI:  rd_word = mtimecmp_q[63:32];
            A_TIME_LO: rd_word = mtime_q[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            A_TIME_HI: rd_word = shadow_q;
`else
            A_TIME_HI: rd_word = mtime_q[63:32];
`endif
            default:   rd_word = 32'd0;
        endcase
        rdata_d = rd_en ? rd_word : rdata_q;
    end

`ifdef MTIMER_SNAPSHOT_EN
    always_comb begin
        shadow_d = shadow_q;
        if (rd_en && (addr_w == A_TIME_LO)) begin
            shadow_d = mtime_q[63:32];
        end
        if (wr_en && (addr_w == A_TIME_HI)) begin
            shadow_d = bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= 32'd0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt_q   <= 16'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            ti_q       <= 1'b1;
        end else begin
            ps_cnt_q   <= ps_cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rd_en;
            ti_q       <= ~(mtime_q >= mtimecmp_q);
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign ti         = ti_q;

endmodule

// File: tb/tb_mtimer.sv
module tb_mtimer;

    localparam logic [31:0] A_CMP_LO  = 32'h0200_4000;
    localparam logic [31:0] A_CMP_HI  = 32'h0200_4004;
    localparam logic [31:0] A_TIME_LO = 32'h0200_BFF8;
    localparam logic [31:0] A_TIME_HI = 32'h0200_BFFC;
    localparam logic [31:0] A_UNDEC   = 32'h0200_0010;

    logic clk;
    logic rst1;
    logic rst4;
    logic ti1;
    logic ti4;

    int n_cmp;
    int n_bad;

    mtimer_if bus1();
    mtimer_if bus4();

    mtimer #(.BASE(32'h0200_0000), .PRESCALE(1)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave),
        .ti  (ti1)
    );

    mtimer #(.BASE(32'h0200_0000), .PRESCALE(4)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4.slave),
        .ti  (ti4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we_n;
        logic        re_n;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_rvalid;
        logic        exp_ti;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic we_n, input logic re_n,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_rvalid,
                                input logic exp_ti);
        vec_t v;
        v.we_n       = we_n;
        v.re_n       = re_n;
        v.addr       = addr;
        v.wdata      = wdata;
        v.exp_rdata  = exp_rdata;
        v.exp_rvalid = exp_rvalid;
        v.exp_ti     = exp_ti;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic we_n, input logic re_n,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus1.we    = we_n;
        bus1.re    = re_n;
        bus1.addr  = addr;
        bus1.wdata = wdata;
    endtask

    task automatic drive4(input logic we_n, input logic re_n,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus4.we    = we_n;
        bus4.re    = re_n;
        bus4.addr  = addr;
        bus4.wdata = wdata;
    endtask

    task automatic wr1(input logic [31:0] addr, input logic [31:0] data);
        drive1(1'b0, 1'b1, addr, data);
        step();
        drive1(1'b1, 1'b1, 32'd0, 32'd0);
    endtask

    task automatic rd1(input string name, input logic [31:0] addr, input logic [31:0] exp);
        drive1(1'b1, 1'b0, addr, 32'd0);
        step();
        drive1(1'b1, 1'b1, 32'd0, 32'd0);
        check({name, ".rdata"}, bus1.rdata, exp);
        check({name, ".rvalid"}, {31'd0, bus1.rvalid}, 32'd1);
    endtask

    task automatic wr4(input logic [31:0] addr, input logic [31:0] data);
        drive4(1'b0, 1'b1, addr, data);
        step();
        drive4(1'b1, 1'b1, 32'd0, 32'd0);
    endtask

    task automatic rd4(input string name, input logic [31:0] addr, input logic [31:0] exp);
        drive4(1'b1, 1'b0, addr, 32'd0);
        step();
        drive4(1'b1, 1'b1, 32'd0, 32'd0);
        check({name, ".rdata"}, bus4.rdata, exp);
        check({name, ".rvalid"}, {31'd0, bus4.rvalid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // With PRESCALE=1 mtime equals the number of edges since reset
        // release, so vector k sees pre-edge mtime == k.
        vecs[0]  = mk(1, 0, A_CMP_HI,  32'h0,         32'hFFFF_FFFF, 1, 1);
        vecs[1]  = mk(1, 0, A_CMP_LO,  32'h0,         32'hFFFF_FFFF, 1, 1);
        vecs[2]  = mk(1, 0, A_TIME_LO, 32'h0,         32'd2,         1, 1);
        vecs[3]  = mk(1, 0, A_TIME_HI, 32'h0,         32'd0,         1, 1);
        vecs[4]  = mk(1, 1, 32'h0,     32'h0,         32'd0,         0, 1);
        vecs[5]  = mk(1, 0, A_UNDEC,   32'h0,         32'd0,         1, 1);
        vecs[6]  = mk(0, 1, A_UNDEC,   32'hDEAD_BEEF, 32'd0,         0, 1);
        vecs[7]  = mk(1, 0, A_CMP_LO,  32'h0,         32'hFFFF_FFFF, 1, 1);
        vecs[8]  = mk(1, 0, A_TIME_LO, 32'h0,         32'd8,         1, 1);
        vecs[9]  = mk(0, 1, A_CMP_LO,  32'd20,        32'd8,         0, 1);
        vecs[10] = mk(0, 1, A_CMP_HI,  32'd0,         32'd8,         0, 1);
        vecs[11] = mk(1, 0, A_CMP_LO,  32'h0,         32'd20,        1, 1);
        vecs[12] = mk(1, 0, A_CMP_HI,  32'h0,         32'd0,         1, 1);
        vecs[13] = mk(1, 0, A_TIME_HI, 32'h0,         32'd0,         1, 1);
        vecs[14] = mk(1, 1, 32'h0,     32'h0,         32'd0,         0, 1);
        vecs[15] = mk(1, 1, 32'h0,     32'h0,         32'd0,         0, 1);
        vecs[16] = mk(1, 1, 32'h0,     32'h0,         32'd0,         0, 1);
        vecs[17] = mk(1, 1, 32'h0,     32'h0,         32'd0,         0, 1);
        vecs[18] = mk(1, 1, 32'h0,     32'h0,         32'd0,         0, 1);
        vecs[19] = mk(1, 1, 32'h0,     32'h0,         32'd0,         0, 1);
        vecs[20] = mk(1, 1, 32'h0,     32'h0,         32'd0,         0, 0);
        vecs[21] = mk(0, 1, A_CMP_LO,  32'd100,       32'd0,         0, 0);
        vecs[22] = mk(1, 1, 32'h0,     32'h0,         32'd0,         0, 1);
        vecs[23] = mk(1, 1, 32'h0,     32'h0,         32'd0,         0, 1);
        vecs[24] = mk(1, 0, A_CMP_LO,  32'h0,         32'd100,       1, 1);

        rst1 = 1'b1;
        rst4 = 1'b1;
        drive1(1'b1, 1'b1, 32'd0, 32'd0);
        drive4(1'b1, 1'b1, 32'd0, 32'd0);
        step();
        step();
        rst1 = 1'b0;

        check("reset.rdata",  bus1.rdata, 32'd0);
        check("reset.rvalid", {31'd0, bus1.rvalid}, 32'd0);
        check("reset.ti",     {31'd0, ti1}, 32'd1);

        for (int k = 0; k < 25; k++) begin
            drive1(vecs[k].we_n, vecs[k].re_n, vecs[k].addr, vecs[k].wdata);
            step();
            check($sformatf("vec%0d.rdata", k),  bus1.rdata, vecs[k].exp_rdata);
            check($sformatf("vec%0d.rvalid", k), {31'd0, bus1.rvalid}, {31'd0, vecs[k].exp_rvalid});
            check($sformatf("vec%0d.ti", k),     {31'd0, ti1}, {31'd0, vecs[k].exp_ti});
        end
        drive1(1'b1, 1'b1, 32'd0, 32'd0);

        // Carry from low word into high word.
        wr1(A_TIME_LO, 32'hFFFF_FFFE);
        wr1(A_TIME_HI, 32'h0);
        step();
        step();
        rd1("carry.lo", A_TIME_LO, 32'h0);
        rd1("carry.hi", A_TIME_HI, 32'h1);

        // Snapshot: lo read at 0x1_FFFF_FFFF, then the carry lands before hi.
        wr1(A_TIME_HI, 32'h1);
        wr1(A_TIME_LO, 32'hFFFF_FFFF);
        rd1("snap.lo", A_TIME_LO, 32'hFFFF_FFFF);
`ifdef MTIMER_SNAPSHOT_EN
        rd1("snap.hi", A_TIME_HI, 32'h1);
`else
        rd1("snap.hi", A_TIME_HI, 32'h2);
`endif

        // Same-cycle read and write of one address returns the old value.
        drive1(1'b0, 1'b0, A_CMP_LO, 32'd55);
        step();
        drive1(1'b1, 1'b1, 32'd0, 32'd0);
        check("rw_same.rdata", bus1.rdata, 32'd100);
        rd1("rw_same.after", A_CMP_LO, 32'd55);

        // Reset outranks a simultaneous write.
        rst1 = 1'b1;
        drive1(1'b0, 1'b1, A_CMP_LO, 32'd5);
        step();
        rst1 = 1'b0;
        drive1(1'b1, 1'b1, 32'd0, 32'd0);
        check("midrst.ti",     {31'd0, ti1}, 32'd1);
        check("midrst.rvalid", {31'd0, bus1.rvalid}, 32'd0);
        check("midrst.rdata",  bus1.rdata, 32'd0);
        rd1("midrst.cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);

        // PRESCALE=4: ticks land on edges 4, 8, 12, 16, 20 after release.
        step();
        step();
        rst4 = 1'b0;
        check("ps.reset.ti", {31'd0, ti4}, 32'd1);
        check("ps.reset.rvalid", {31'd0, bus4.rvalid}, 32'd0);
        for (int i = 0; i < 12; i++) step();
        rd4("ps.after12", A_TIME_LO, 32'd3);
        step();
        step();
        wr4(A_TIME_LO, 32'h50);
        rd4("ps.tickwrite", A_TIME_LO, 32'h50);
        wr4(A_CMP_LO, 32'd7);
        step();
        rd4("ps.hold", A_TIME_LO, 32'h50);
        rd4("ps.next", A_TIME_LO, 32'h51);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mtimer.md
# mtimer

Machine-timer source feeding the `ti` input of the CSR/interrupt unit. Holds a 64-bit free-running `mtime` and a 64-bit `mtimecmp`, both word-accessible over the core's data bus. Drives the active-low timer-interrupt line whenever `mtime >= mtimecmp`. Software clears the interrupt by rewriting `mtimecmp`; there is no other acknowledge path.

## Interface

Parameters:
- `BASE`, default `32'h0200_0000`: bus base address; the block decodes `BASE + 0x4000..0x4007` (`mtimecmp`) and `BASE + 0xBFF8..0xBFFF` (`mtime`).
- `PRESCALE`, default `1`: `clk` cycles per `mtime` increment; legal range 1..65535.

Ports:
- `clk`: in, 1. Single clock; all state updates on its rising edge.
- `rst`: in, 1. Synchronous, active-high reset.
- `addr`: in, 32. Word byte-address; bits [1:0] are ignored.
- `wdata`: in, 32. Write data.
- `we`: in, 1. Write enable, ACTIVE LOW.
- `re`: in, 1. Read enable, ACTIVE LOW.
- `rdata`: out, 32. Registered read data.
- `rvalid`: out, 1. `rdata` valid, active high, one-cycle pulse.
- `ti`: out, 1. Timer interrupt to the CSR unit, ACTIVE LOW, registered.

## Operation

Registers (word offsets from `BASE`):
- `0x4000` is `mtimecmp[31:0]`.
- `0x4004` is `mtimecmp[63:32]`.
- `0xBFF8` is `mtime[31:0]`.
- `0xBFFC` is `mtime[63:32]`.

Reset values:
- `mtime` = 0.
- `mtimecmp` = `64'hFFFF_FFFF_FFFF_FFFF`.
- Prescaler count = 0.
- `rdata` = 0, `rvalid` = 0, `ti` = 1 (inactive).

Prescaler:
- The counter runs 0..PRESCALE-1 and emits `tick` in the cycle where it equals PRESCALE-1, then wraps to 0.
- With `PRESCALE=1`, `tick` is asserted every cycle.

`mtime` update:
- On `tick`, `mtime <= mtime + 1` as a full 64-bit add. The carry from the low word propagates into the high word in the same cycle.
- At `64'hFFFF_FFFF_FFFF_FFFF`, `mtime` wraps to 0.

Writes:
- A write (`we` low, decoded address) updates only the addressed 32-bit half.
- A bus write to either `mtime` half in a `tick` cycle wins. The written half takes `wdata`; the other half holds its value and is not incremented in that cycle, including carry.
- A write to `mtimecmp` does not touch the prescaler.
- Writes to undecoded addresses are ignored.

Reads:
- When `re` is low, `rdata` is loaded with the addressed register in the next cycle and `rvalid` pulses for one cycle.
- An undecoded address returns 0, still with `rvalid`.
- A read returns the pre-edge value when `we` and `re` target the same address in the same cycle.
- Back-to-back reads are accepted every cycle.

Interrupt:
- `ti <= ~(mtime >= mtimecmp)`, an unsigned 64-bit compare on the current registered values.
- Level behaviour only; `ti` stays low until the compare fails.

## Timing

- `mtime` changes one cycle after a `tick` cycle.
- `ti` follows one cycle after `mtime`/`mtimecmp` satisfy the compare, so a write to `mtimecmp` at edge N deasserts `ti` at edge N+1.
- Read latency is 1 cycle: request at edge N, `rdata`/`rvalid` valid after edge N+1.
- Reset asserted mid-operation takes effect at the next edge, regardless of `we`/`re`. Reset outranks writes and ticks.
- There is no stall or back-pressure; the bus master samples `rdata` when `rvalid` is high.

## Configuration

Macro `MTIMER_SNAPSHOT_EN` controls coherent 64-bit reads of `mtime`.

Defined:
- A read of `mtime[31:0]` also captures `mtime[63:32]` into a 32-bit shadow register (reset 0).
- Subsequent reads of `0xBFFC` return the shadow, not the live high word.
- A write to `0xBFFC` updates both the live high word and the shadow.

Not defined:
- No shadow register exists.
- `0xBFFC` returns the live high word.
- Software must use the hi–lo–hi retry sequence.

## Test plan

- **Reset:** Hold `rst` 2 cycles. Require `mtime=0`, `mtimecmp=all ones`, `ti=1`, `rvalid=0`. Read `0x4004`; require `rdata=FFFF_FFFF` with a `rvalid` pulse one cycle later.
- **Carry:** With `PRESCALE=1`, write `mtime` lo=`FFFF_FFFE` and hi=0. After 2 ticks require lo=0 and hi=1.
- **Prescaler:** With `PRESCALE=4`, run 12 cycles after reset and require `mtime=3`. Write `mtime` lo in a `tick` cycle and require the written value, with no increment in that cycle.
- **Interrupt assert and clear:** Write `mtimecmp=10` (hi=0, lo=10). Require `ti` to fall exactly one cycle after `mtime` reaches 10. Write `mtimecmp` lo=100 and require `ti=1` on the following cycle.
- **Snapshot:** Set `mtime=0x0000_0001_FFFF_FFFF`, read lo, let it carry, then read hi. With `MTIMER_SNAPSHOT_EN` require hi=1; without it require hi=2.
- **Undecoded address:** Read `BASE+0x0010` and require `rdata=0` with `rvalid=1`. Write the same address and require no register to change.
